cgate_handshake_sink: RTL
=========================

// Module: cgate_handshake_sink
// PURPOSE
// - Synchronous consumer for the 4-phase bundled-data channel at the output of the C-gate pipeline.
// - Synchronises the asynchronous req_in and captures data_in while req is high.
// - Answers with ack_out and presents each token on a valid/ready stream toward uo_out / the tests.
// - Counts tokens, keeps a running XOR checksum and flags a handshake that stalls.
// PARAMETERS
// - WIDTH       8    bundled-data width
// - SYNC_STAGES 2    flip-flops in the req_in synchroniser (legal range 2..4)
// - TIMEOUT     255  max cycles in WAIT_REQ_LO before timeout_err is set (legal range 1..65535)
// PORTS
// - clk         in   1      system clock
// - rst         in   1      asynchronous, active-high reset
// - ena         in   1      enable; 0 freezes the FSM in place (ack_out holds its value)
// - req_in      in   1      4-phase request from the pipeline; asynchronous to clk
// - data_in     in   WIDTH  bundled data; stable whenever req_in=1
// - ack_out     out  1      4-phase acknowledge back to the pipeline
// - tok_valid   out  1      token available on tok_data
// - tok_data    out  WIDTH  captured token
// - tok_ready   in   1      consumer accepts the token when tok_valid&tok_ready
// - tok_count   out  16     tokens accepted on the stream, wraps 0xFFFF->0
// - checksum    out  WIDTH  XOR of all accepted tok_data
// - timeout_err out  1      sticky stall flag
// BEHAVIOUR
// - Reset (async assert, sync release): IDLE, ack_out=0, tok_valid=0, tok_data=0, tok_count=0, checksum=0, timeout_err=0, sync chain=0.
// - req_s is req_in after SYNC_STAGES flops; only req_s is used by the FSM.
// - FSM (advances only when ena=1):
//   - IDLE: if req_s=1 && tok_valid=0, capture tok_data<=data_in, set tok_valid, go to ACK_HI. If tok_valid=1, stay in IDLE (backpressure: ack withheld).
//   - ACK_HI: ack_out<=1 and go to WAIT_REQ_LO.
//   - WAIT_REQ_LO: hold ack_out=1 until req_s=0, then ack_out<=0 and go to IDLE.
//   - Stall timer: clears on entry to WAIT_REQ_LO and counts cycles there. Reaching TIMEOUT sets timeout_err, which stays set until rst. The FSM keeps waiting.
// - Latency:
//   - req_in rise to capture edge: SYNC_STAGES+1 clk.
//   - ack_out rises 1 clk after capture.
//   - req_in fall to ack_out fall: SYNC_STAGES+1 clk.
// - Stream: tok_valid stays high and tok_data stable until tok_valid&tok_ready.
// - On accept: tok_valid<=0, tok_count<=tok_count+1 (mod 2^16), checksum<=checksum^tok_data.
// - Simultaneous accept and req_s=1 in IDLE: no capture in that cycle; capture happens the next cycle (no bypass).
// - tok_ready is honoured even when ena=0. The counters still update.
// - rst mid-handshake: ack_out drops immediately and the pending token is discarded. The pipeline must then see req low before a new token.
// - ena=0: all outputs hold; the sync chain keeps sampling.
// TESTING
// - Reset: assert rst with req_in=1 -> ack_out=0, tok_valid=0, tok_count=0, checksum=0 with no clk edge needed.
// - Single token (tok_ready=1): req_in=1 with data_in=0xA5 -> tok_data=0xA5 and tok_valid at cycle 3, ack_out=1 at cycle 4. Then drop req_in -> ack_out=0 three cycles later; tok_count=1, checksum=0xA5.
// - Backpressure (tok_ready=0): token 0x3C accepted, second req with 0xC3 -> ack_out stays 0 while tok_valid=1. Raise tok_ready -> 0x3C consumed, then 0xC3 captured; final checksum=0xFF, tok_count=2.
// - Stall: hold req_in=1 for TIMEOUT+5 cycles after ack -> timeout_err=1 exactly TIMEOUT cycles after entry to WAIT_REQ_LO. Release req -> ack_out falls, timeout_err stays 1.
// - Wrap: preload tok_count=0xFFFF via 65535 tokens (or force), one more token -> tok_count=0x0000.
// - Reset mid-handshake: rst during WAIT_REQ_LO -> ack_out=0 same cycle, tok_valid=0, no count increment.

Source files
------------

// File: rtl/cgate_handshake_sink_if.sv
// rtl/cgate_handshake_sink_if.sv - bundled-data channel and token stream bundle for cgate_handshake_sink
//
// Signals:
//   req_in    4-phase request from the C-gate pipeline (asynchronous to clk)
//   data_in   bundled data, stable while req_in=1
//   ack_out   4-phase acknowledge back to the pipeline
//   tok_valid token available on tok_data
//   tok_data  captured token
//   tok_ready downstream consumer accepts the token when tok_valid&tok_ready
// Modports:
//   master    pipeline + downstream consumer side
//   slave     the sink itself
interface cgate_handshake_sink_if #(
    parameter int WIDTH = 8
);
    logic             req_in;
    logic [WIDTH-1:0] data_in;
    logic             ack_out;
    logic             tok_valid;
    logic [WIDTH-1:0] tok_data;
    logic             tok_ready;

    modport master (
        output req_in,
        output data_in,
        output tok_ready,
        input  ack_out,
        input  tok_valid,
        input  tok_data
    );

    modport slave (
        input  req_in,
        input  data_in,
        input  tok_ready,
        output ack_out,
        output tok_valid,
        output tok_data
    );
endinterface

// File: rtl/cgate_handshake_sink.sv
// rtl/cgate_handshake_sink.sv - synchronous 4-phase bundled-data sink feeding a valid/ready token stream
//
// Purpose: synchronises req_in, captures data_in into a one-deep token register,
// acknowledges the pipeline, and offers the token downstream. Keeps a token
// count, a running XOR checksum and a sticky stall flag.
// Ports:
//   clk           system clock
//   rst           asynchronous active-high reset
//   ena_i         enable; 0 freezes the FSM (stream accept still honoured)
//   bus           cgate_handshake_sink_if.slave (req/data/ack + token stream)
//   tok_count_o   tokens accepted downstream, wraps 0xFFFF->0
//   checksum_o    XOR of all accepted tokens
//   timeout_err_o sticky: ack held high for TIMEOUT cycles without req falling
module cgate_handshake_sink #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ena_i,
    cgate_handshake_sink_if.slave   bus,
    output logic [15:0]             tok_count_o,
    output logic [WIDTH-1:0]        checksum_o,
    output logic                    timeout_err_o
);

    localparam logic [15:0] TIMEOUT_C  = 16'(TIMEOUT);
    localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        ACK_HI      = 2'd1,
        WAIT_REQ_LO = 2'd2
    } state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    logic                   ack_q;
    logic                   tok_valid_q;
    logic [WIDTH-1:0]       tok_data_q;
    logic [15:0]            timer_q;
    logic                   timeout_err_q;
    logic [15:0]            tok_count_q;
    logic [15:0]            tok_count_d;
    logic [WIDTH-1:0]       checksum_q;
    logic [WIDTH-1:0]       checksum_d;
    logic                   accept;

    // Synchroniser keeps sampling regardless of ena_i so req_s is current
    // the moment the FSM is re-enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.req_in};
        end
    end

    assign req_s = sync_q[SYNC_STAGES-1];

    // Downstream accept is independent of ena_i.
    assign accept = tok_valid_q & bus.tok_ready;

    always_comb begin
        tok_count_d = tok_count_q;
        checksum_d  = checksum_q;
        if (accept) begin
            tok_count_d = tok_count_q + 16'd1;
            checksum_d  = checksum_q ^ tok_data_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tok_count_q <= '0;
            checksum_q  <= '0;
        end else begin
            tok_count_q <= tok_count_d;
            checksum_q  <= checksum_d;
        end
    end

    // Handshake FSM. Capture is gated on the registered tok_valid_q, so a
    // token accepted this cycle frees the slot only from the next cycle on
    // (no same-cycle bypass).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            ack_q         <= 1'b0;
            tok_valid_q   <= 1'b0;
            tok_data_q    <= '0;
            timer_q       <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            if (accept) begin
                tok_valid_q <= 1'b0;
            end
            if (ena_i) begin
                case (state_q)
                    IDLE: begin
                        if (req_s && !tok_valid_q) begin
                            tok_data_q  <= bus.data_in;
                            tok_valid_q <= 1'b1;
                            state_q     <= ACK_HI;
                        end
                    end
                    ACK_HI: begin
                        ack_q   <= 1'b1;
                        timer_q <= '0;
                        state_q <= WAIT_REQ_LO;
                    end
                    WAIT_REQ_LO: begin
                        if (!req_s) begin
                            ack_q   <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            // Timer saturates at TIMEOUT; the flag is sticky
                            // and the FSM simply keeps waiting.
                            if (timer_q != TIMEOUT_C) begin
                                timer_q <= timer_q + 16'd1;
                            end
                            if (timer_q == TIMEOUT_M1) begin
                                timeout_err_q <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        ack_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.ack_out    = ack_q;
    assign bus.tok_valid  = tok_valid_q;
    assign bus.tok_data   = tok_data_q;
    assign tok_count_o    = tok_count_q;
    assign checksum_o     = checksum_q;
    assign timeout_err_o  = timeout_err_q;

endmodule
